// File: rtl/lc3_seq_ctrl_if.sv
// Sequencer <-> memory/stage-block bundle: memory completions and fetched instruction in,
// stage enables, data-memory state and retire/timeout status out.
interface lc3_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             complete_instr;
    logic             complete_data;
    logic [15:0]      ir;
    logic [2:0]       nzp;
    logic             enable_fetch;
    logic             enable_decode;
    logic             enable_execute;
    logic             enable_writeback;
    logic             enable_updatePC;
    logic             br_taken;
    logic [1:0]       mem_state;
    logic [3:0]       state;
    logic             instr_done;
    logic             mem_timeout;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  complete_instr, complete_data, ir, nzp,
        output enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, state, instr_done,
               mem_timeout, instr_count
    );

    modport slave (
        output complete_instr, complete_data, ir, nzp,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_updatePC, br_taken, mem_state, state, instr_done,
               mem_timeout, instr_count
    );
endinterface

// File: rtl/lc3_seq_ctrl.sv
// LC3 multicycle sequencer: FETCH/DECODE/EXEC/mem/WB/UPDPC with Moore stage enables.
// ALU op 5 cycles + waits; FETCH stalls on complete_instr forever, data waits bounded by MEM_TIMEOUT.
module lc3_seq_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    lc3_seq_ctrl_if.master bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC    = 4'd2;
    localparam logic [3:0] S_MEM_IND = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_MEM_WR  = 4'd5;
    localparam logic [3:0] S_WB      = 4'd6;
    localparam logic [3:0] S_UPDPC   = 4'd7;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam int              WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [3:0]        state_q, state_d;
    logic [15:0]       ir_q;
    logic              br_q, br_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_mem, next_in_mem, timeout_hit, run;

    assign run         = !reset;
    assign in_mem      = (state_q == S_MEM_IND) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign next_in_mem = (state_d == S_MEM_IND) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    // A completion arriving on the last allowed cycle beats the timeout.
    assign timeout_hit = TIMEOUT_EN && in_mem && !bus.complete_data && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        case (state_q)
            S_FETCH:   if (bus.complete_instr) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXEC;
            S_EXEC: begin
                br_d = 1'b0;
                case (ir_q[15:12])
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WB;
                    OP_LD, OP_LDR:                  state_d = S_MEM_RD;
                    OP_ST, OP_STR:                  state_d = S_MEM_WR;
                    OP_LDI, OP_STI:                 state_d = S_MEM_IND;
                    OP_BR: begin
                        br_d    = |(ir_q[11:9] & bus.nzp);
                        state_d = S_UPDPC;
                    end
                    OP_JMP: begin
                        br_d    = 1'b1;
                        state_d = S_UPDPC;
                    end
                    default:                        state_d = S_UPDPC;
                endcase
            end
            // ir_q[12] separates STI (1011) from LDI (1010).
            S_MEM_IND: if (bus.complete_data) state_d = ir_q[12] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (bus.complete_data) state_d = S_WB;
            S_MEM_WR:  if (bus.complete_data) state_d = S_UPDPC;
            S_WB:      state_d = S_UPDPC;
            S_UPDPC:   state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
        if (timeout_hit) begin
            state_d = S_UPDPC;
            br_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ir_q     <= 16'h0000;
            br_q     <= 1'b0;
            wait_cnt <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            if (state_q == S_FETCH && bus.complete_instr)
                ir_q <= bus.ir;
            if (next_in_mem && state_d != state_q)
                wait_cnt <= '0;
            else if (in_mem && !bus.complete_data)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_q == S_UPDPC)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.mem_state = 2'd3;
        if (run) begin
            case (state_q)
                S_MEM_IND: bus.mem_state = 2'd1;
                S_MEM_RD:  bus.mem_state = 2'd0;
                S_MEM_WR:  bus.mem_state = 2'd2;
                default:   bus.mem_state = 2'd3;
            endcase
        end
    end

    assign bus.enable_fetch     = run && (state_q == S_FETCH);
    assign bus.enable_decode    = run && (state_q == S_DECODE);
    assign bus.enable_execute   = run && (state_q == S_EXEC);
    assign bus.enable_writeback = run && (state_q == S_WB);
    assign bus.enable_updatePC  = run && (state_q == S_UPDPC);
    assign bus.br_taken         = (state_q == S_UPDPC) && br_q;
    assign bus.state            = state_q;
    assign bus.instr_done       = run && (state_q == S_UPDPC);
    assign bus.mem_timeout      = run && timeout_hit;
    assign bus.instr_count      = cnt_q;
endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Bench for lc3_seq_ctrl: each instruction is planned as a per-cycle trace of inputs and
// expected outputs, driven cycle by cycle and compared on the falling edge.
module tb_lc3_seq_ctrl;
    localparam int T  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lc3_seq_ctrl_if #(.CNT_W(CW)) bus();
    lc3_seq_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic          rst, ci, cd;
        logic [15:0]   ir;
        logic [2:0]    nzp;
        logic [3:0]    st;
        logic [1:0]    ms;
        logic [4:0]    en;
        logic          br, done, tmo;
        logic [CW-1:0] cnt;
    } rec_t;

    rec_t plan[$];
    rec_t exp_q[$];
    rec_t cur;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [CW-1:0] m_cnt = '0;
    int   st_log[$], ms_log[$], br_log[$], tmo_log[$], wb_log[$], cnt_log[$];
    int   q_st[$];
    bit   q_ci[$], q_cd[$], q_tm[$];

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    // Expectation nibble i sits at exp[4*i +: 4].
    task automatic check_seq(input string nm, input int got[$], input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : -1, int'(exp[4*i +: 4]));
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic emit(input logic rst, ci, cd, input logic [15:0] ir, input logic [2:0] nz,
                        input int st, input logic br, input logic tmo);
        rec_t r;
        r.rst = rst; r.ci = ci; r.cd = cd; r.ir = ir; r.nzp = nz; r.st = 4'(st);
        r.en  = rst ? 5'b0 : {st == 0, st == 1, st == 2, st == 6, st == 7};
        case (st)
            3:       r.ms = 2'd1;
            4:       r.ms = 2'd0;
            5:       r.ms = 2'd2;
            default: r.ms = 2'd3;
        endcase
        if (rst) r.ms = 2'd3;
        r.br   = (st == 7) && br;
        r.done = !rst && (st == 7);
        r.tmo  = !rst && tmo;
        r.cnt  = m_cnt;
        plan.push_back(r);
        if (rst) m_cnt = '0;
        else if (st == 7) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic add_cyc(input int st, input bit ci, input bit cd, input bit tm);
        q_st.push_back(st); q_ci.push_back(ci); q_cd.push_back(cd); q_tm.push_back(tm);
    endtask

    // w = cycles without completion before complete_data; w >= T means it never arrives.
    task automatic mem_phase(input int st, input int w, output bit to);
        to = 1'b0;
        if (w < T) begin
            for (int i = 0; i < w; i++) add_cyc(st, rb(), 1'b0, 1'b0);
            add_cyc(st, rb(), 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < T - 1; i++) add_cyc(st, rb(), 1'b0, 1'b0);
            add_cyc(st, rb(), 1'b0, 1'b1);
            to = 1'b1;
        end
    endtask

    task automatic add_instr(input logic [15:0] ins, input logic [2:0] nz,
                             input int fw, input int w1, input int w2, input int abort_at);
        bit to;
        logic br;
        logic [3:0] op;
        logic [15:0] irv;
        op = ins[15:12];
        br = 1'b0;
        q_st.delete(); q_ci.delete(); q_cd.delete(); q_tm.delete();
        for (int i = 0; i < fw; i++) add_cyc(0, 1'b0, rb(), 1'b0);
        add_cyc(0, 1'b1, rb(), 1'b0);
        add_cyc(1, rb(), rb(), 1'b0);
        add_cyc(2, rb(), rb(), 1'b0);
        to = 1'b0;
        case (op)
            4'h2, 4'h6: mem_phase(4, w1, to);
            4'h3, 4'h7: mem_phase(5, w1, to);
            4'hA, 4'hB: begin
                mem_phase(3, w1, to);
                if (!to) mem_phase((op == 4'hA) ? 4 : 5, w2, to);
            end
            default: ;
        endcase
        if (!to && (op inside {4'h1, 4'h5, 4'h9, 4'hE, 4'h2, 4'h6, 4'hA}))
            add_cyc(6, rb(), rb(), 1'b0);
        add_cyc(7, rb(), rb(), 1'b0);
        if (op == 4'h0) br = |(ins[11:9] & nz);
        else if (op == 4'hC) br = 1'b1;
        for (int i = 0; i < q_st.size(); i++) begin
            irv = (i == fw) ? ins : 16'($urandom);
            if (i == abort_at) begin
                emit(1'b1, q_ci[i], q_cd[i], irv, nz, q_st[i], br, 1'b0);
                break;
            end
            emit(1'b0, q_ci[i], q_cd[i], irv, nz, q_st[i], br, q_tm[i]);
        end
    endtask

    task automatic rand_instr(input bit allow_abort);
        int ab;
        ab = -1;
        if (allow_abort && $urandom_range(0, 9) == 0) ab = $urandom_range(0, 9);
        add_instr(16'($urandom), 3'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 5), $urandom_range(0, 5), ab);
    endtask

    task automatic run_plan();
        rec_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            reset              = r.rst;
            bus.complete_instr = r.ci;
            bus.complete_data  = r.cd;
            bus.ir             = r.ir;
            bus.nzp            = r.nzp;
            exp_q.push_back(r);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        st_log.delete(); ms_log.delete(); br_log.delete();
        tmo_log.delete(); wb_log.delete(); cnt_log.delete();
    endtask

    function automatic int sum(input int q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("state", int'(bus.state), int'(cur.st));
            check("ctrl", int'({bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                                bus.enable_writeback, bus.enable_updatePC, bus.br_taken,
                                bus.instr_done, bus.mem_timeout, bus.mem_state}),
                          int'({cur.en, cur.br, cur.done, cur.tmo, cur.ms}));
            check("count", int'(bus.instr_count), int'(cur.cnt));
            st_log.push_back(int'(bus.state));
            ms_log.push_back(int'(bus.mem_state));
            br_log.push_back(int'(bus.br_taken));
            tmo_log.push_back(int'(bus.mem_timeout));
            wb_log.push_back(int'(bus.enable_writeback));
            cnt_log.push_back(int'(bus.instr_count));
        end
    end

    initial begin
        bus.complete_instr = 1'b0;
        bus.complete_data  = 1'b0;
        bus.ir             = 16'h0000;
        bus.nzp            = 3'b000;
        @(posedge clk);
        #1;
        emit(1'b1, 1'b0, 1'b0, 16'h0000, 3'b000, 0, 1'b0, 1'b0);
        run_plan();

        clear_logs();
        add_instr(16'h1261, 3'b001, 1, 0, 0, -1);
        run_plan();
        check_seq("add states", st_log, 6, 64'h762100);
        check("add count", int'(bus.instr_count), 1);

        clear_logs();
        add_instr(16'hA202, 3'b010, 0, 1, 1, -1);
        run_plan();
        check_seq("ldi states", st_log, 9, 64'h764433210);
        check_seq("ldi mem_state", ms_log, 9, 64'h330011333);
        check("ldi writeback", (wb_log.size() > 7) ? wb_log[7] : -1, 1);

        clear_logs();
        add_instr(16'hB202, 3'b010, 0, 0, 0, -1);
        run_plan();
        check_seq("sti states", st_log, 6, 64'h753210);
        check("sti no writeback", sum(wb_log), 0);

        clear_logs();
        add_instr(16'h0405, 3'b010, 0, 0, 0, -1);
        run_plan();
        check("brz taken", (br_log.size() > 3) ? br_log[3] : -1, 1);
        clear_logs();
        add_instr(16'h0405, 3'b100, 0, 0, 0, -1);
        run_plan();
        check("brz not taken", (br_log.size() > 3) ? br_log[3] : -1, 0);
        clear_logs();
        add_instr(16'hC1C0, 3'b000, 0, 0, 0, -1);
        run_plan();
        check_seq("jmp states", st_log, 4, 64'h7210);
        check("jmp taken", (br_log.size() > 3) ? br_log[3] : -1, 1);

        clear_logs();
        add_instr(16'h2205, 3'b001, 0, 5, 0, -1);
        run_plan();
        check_seq("ld timeout states", st_log, 8, 64'h74444210);
        check("ld timeout pulse", (tmo_log.size() > 6) ? tmo_log[6] : -1, 1);
        check("ld timeout early", (tmo_log.size() > 5) ? tmo_log[5] : -1, 0);
        clear_logs();
        add_instr(16'h2205, 3'b001, 0, 3, 0, -1);
        run_plan();
        check_seq("ld late-complete states", st_log, 9, 64'h764444210);
        check("ld late-complete no timeout", sum(tmo_log), 0);

        // Reset lands on the second MEM_WR cycle of an ST, then an ADD follows.
        clear_logs();
        add_instr(16'h3205, 3'b001, 0, 3, 0, 4);
        add_instr(16'h1261, 3'b001, 0, 0, 0, -1);
        run_plan();
        check_seq("abort states", st_log, 10, 64'h7621055210);
        check_seq("abort mem_state", ms_log, 6, 64'h332333);
        check("abort count", (cnt_log.size() > 5) ? cnt_log[5] : -1, 0);

        // Count is 1 here; 255 more retires wrap the 8-bit counter to 0.
        for (int i = 0; i < 255; i++) rand_instr(1'b0);
        run_plan();
        check("count wrap", int'(bus.instr_count), 0);

        for (int i = 0; i < 80; i++) rand_instr(1'b1);
        run_plan();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
